// File: rtl/hrm_pkg.sv
// Shared HRM package: default data width, debug-display dump chip selects,
// and the level-width helper used by the mailbox.
package hrm_pkg;

  localparam int HRM_DW = 8;

  // Dump chip-select codes feeding the debug display mux
  localparam logic [2:0] DMP_INBOX  = 3'd0;
  localparam logic [2:0] DMP_OUTBOX = 3'd1;
  localparam logic [2:0] DMP_PC     = 3'd2;
  localparam logic [2:0] DMP_RAM    = 3'd3;
  localparam logic [2:0] DMP_REG    = 3'd4;
  localparam logic [2:0] DMP_INSTR  = 3'd5;
  localparam logic [2:0] DMP_MBOX   = 3'd6;

  // Bits needed to count 0..depth inclusive
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hrm_mbox_chan.sv
// One mailbox channel: FWFT FIFO with flush, sticky overflow, level and
// a combinational dump read at an offset from the head.
module hrm_mbox_chan
  import hrm_pkg::*;
#(
  parameter int DW      = HRM_DW,
  parameter int LGDEPTH = 5,
  parameter int LW      = lvl_w(2**LGDEPTH)
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_wr,
  input  logic [DW-1:0]      i_wdata,
  input  logic               i_rd,
  input  logic               i_clr,
  output logic [DW-1:0]      o_rdata,
  output logic               o_empty_n,
  output logic               o_full,
  output logic [LW-1:0]      o_level,
  output logic               o_ovf,
  input  logic [LGDEPTH-1:0] i_dmp_pos,
  output logic [DW-1:0]      o_dmp_data,
  output logic               o_dmp_valid
);

  localparam int DEPTH = 2**LGDEPTH;

  logic [DW-1:0]      mem_q [DEPTH];
  logic [LGDEPTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               ovf_q, ovf_d;
  logic               full, empty_n, push, pop;
  logic [LGDEPTH-1:0] dmp_idx;

  assign full    = (level_q == LW'(DEPTH));
  assign empty_n = (level_q != '0);
  // A simultaneous pop frees the slot, so a full FIFO still takes the push
  assign push    = i_wr && (!full || i_rd);
  assign pop     = i_rd && empty_n;

  // Next-state: flush wins over traffic; overflow latches on a dropped push
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (i_clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
      if (i_wr && full && !i_rd) ovf_d = 1'b1;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage write; contents survive reset and flush
  always_ff @(posedge clk) begin
    if (i_rst_n && !i_clr && push) mem_q[wptr_q] <= i_wdata;
  end

  assign o_rdata   = empty_n ? mem_q[rptr_q] : '0;
  assign o_empty_n = empty_n;
  assign o_full    = full;
  assign o_level   = level_q;
  assign o_ovf     = ovf_q;

  assign dmp_idx     = rptr_q + i_dmp_pos;
  assign o_dmp_valid = (LW'(i_dmp_pos) < level_q);
  assign o_dmp_data  = o_dmp_valid ? mem_q[dmp_idx] : '0;

endmodule

// File: rtl/hrm_mailbox.sv
// Multi-channel HRM mailbox: NCH independent FWFT channels plus a debug
// dump mux. Define HRM_MAILBOX_DUMP_EN to enable the dump port; otherwise
// the dump outputs are tied to 0.
module hrm_mailbox
  import hrm_pkg::*;
#(
  parameter int DW      = HRM_DW,
  parameter int LGDEPTH = 5,
  parameter int NCH     = 2
) (
  input  logic                              clk,
  input  logic                              i_rst_n,
  input  logic [NCH-1:0]                    i_wr,
  input  logic [NCH*DW-1:0]                 i_wdata,
  input  logic [NCH-1:0]                    i_rd,
  output logic [NCH*DW-1:0]                 o_rdata,
  output logic [NCH-1:0]                    o_empty_n,
  output logic [NCH-1:0]                    o_full,
  output logic [NCH*lvl_w(2**LGDEPTH)-1:0]  o_level,
  output logic [NCH-1:0]                    o_ovf,
  input  logic [NCH-1:0]                    i_clr,
  input  logic [2:0]                        i_dmp_ch,
  input  logic [LGDEPTH-1:0]                i_dmp_pos,
  output logic [DW-1:0]                     o_dmp_data,
  output logic                              o_dmp_valid
);

  localparam int LW = lvl_w(2**LGDEPTH);

  logic [NCH-1:0][DW-1:0] dmp_data;
  logic [NCH-1:0]         dmp_valid;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    hrm_mbox_chan #(.DW(DW), .LGDEPTH(LGDEPTH), .LW(LW)) u_chan (
      .clk         (clk),
      .i_rst_n     (i_rst_n),
      .i_wr        (i_wr[c]),
      .i_wdata     (i_wdata[c*DW +: DW]),
      .i_rd        (i_rd[c]),
      .i_clr       (i_clr[c]),
      .o_rdata     (o_rdata[c*DW +: DW]),
      .o_empty_n   (o_empty_n[c]),
      .o_full      (o_full[c]),
      .o_level     (o_level[c*LW +: LW]),
      .o_ovf       (o_ovf[c]),
      .i_dmp_pos   (i_dmp_pos),
      .o_dmp_data  (dmp_data[c]),
      .o_dmp_valid (dmp_valid[c])
    );
  end

`ifdef HRM_MAILBOX_DUMP_EN
  // Dump channel select; codes >= NCH match nothing and read as invalid
  always_comb begin
    o_dmp_data  = '0;
    o_dmp_valid = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (i_dmp_ch == 3'(c)) begin
        o_dmp_data  = dmp_data[c];
        o_dmp_valid = dmp_valid[c];
      end
    end
  end
`else
  assign o_dmp_data  = '0;
  assign o_dmp_valid = 1'b0;
  logic unused_dmp;
  assign unused_dmp = ^{i_dmp_ch, dmp_data, dmp_valid};
`endif

endmodule
